// File: rtl/control_movimiento_pkg.sv
// control_movimiento_pkg
// Shared definitions for the motion-control register sequencer: the
// peripheral register map, the sequencer state encoding, the bus
// transaction type and phase encodings, and the index-counter step helper.
// The VERIFY state exists only when CONTROL_MOVIMIENTO_READBACK_EN is defined.
package control_movimiento_pkg;

  localparam logic [3:0] REG_SS      = 4'd0;
  localparam logic [3:0] REG_RV1     = 4'd1;
  localparam logic [3:0] REG_RV2     = 4'd2;
  localparam logic [3:0] REG_RH1     = 4'd3;
  localparam logic [3:0] REG_RH2     = 4'd4;
  localparam logic [3:0] REG_THETA_M = 4'd5;
  localparam logic [3:0] REG_THETA_A = 4'd6;
  localparam logic [3:0] REG_PHI_M   = 4'd7;
  localparam logic [3:0] REG_PHI_A   = 4'd8;
  localparam int unsigned NUM_REGS   = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STOP,
    ST_LOAD,
    ST_START,
`ifdef CONTROL_MOVIMIENTO_READBACK_EN
    ST_VERIFY,
`endif
    ST_ABORT_STOP,
    ST_FIN
  } seq_state_t;

  typedef enum logic {
    XACT_WR,
    XACT_RD
  } xact_t;

  typedef enum logic [1:0] {
    XS_IDLE,
    XS_DRIVE,
    XS_GAP
  } xact_phase_t;

  // Index counter step, saturating at the last register.
  function automatic logic [3:0] idx_inc(input logic [3:0] idx);
    return (idx >= REG_PHI_A) ? REG_PHI_A : idx + 4'd1;
  endfunction

endpackage

// File: rtl/control_movimiento_sequencer_xact.sv
// cm_bus_xact
// Single-transaction bus engine. A one-cycle i_start launches a read or
// write: strobes are driven for WR_CYCLES/RD_CYCLES cycles, then held low
// for GAP_CYCLES idle cycles. Address/data registers only change on start.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_start         launch a transaction (accepted whenever asserted)
//   i_type/i_addr/i_data  transaction type, register index, write data
//   o_last          final cycle of the transaction (next start may be issued)
//   o_sample        last read-drive cycle: read data is valid on the bus
//   o_cs/o_rd/o_wr/o_addr/o_dout  registered peripheral strobes and bus
module cm_bus_xact
  import control_movimiento_pkg::*;
#(
  parameter int unsigned WR_CYCLES  = 1,
  parameter int unsigned RD_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  xact_t       i_type,
  input  logic [3:0]  i_addr,
  input  logic [15:0] i_data,
  output logic        o_last,
  output logic        o_sample,
  output logic        o_cs,
  output logic        o_rd,
  output logic        o_wr,
  output logic [3:0]  o_addr,
  output logic [15:0] o_dout
);

  localparam int unsigned MAX_DRV = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_DRV > GAP_CYCLES) ? MAX_DRV : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  xact_phase_t   r_phase;
  logic [CW-1:0] r_cnt;
  xact_t         r_type;
  logic          r_cs, r_rd, r_wr;
  logic [3:0]    r_addr;
  logic [15:0]   r_dout;
  logic          w_drv_end, w_gap_end;

  assign w_drv_end = (r_phase == XS_DRIVE) &&
                     (r_cnt == ((r_type == XACT_RD) ? RD_LAST : WR_LAST));
  assign w_gap_end = (r_phase == XS_GAP) && (r_cnt == GAP_LAST);
  // Without a gap the transaction ends with its drive phase.
  assign o_last    = HAS_GAP ? w_gap_end : w_drv_end;
  assign o_sample  = w_drv_end && (r_type == XACT_RD);

  assign o_cs   = r_cs;
  assign o_rd   = r_rd;
  assign o_wr   = r_wr;
  assign o_addr = r_addr;
  assign o_dout = r_dout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase <= XS_IDLE;
      r_cnt   <= '0;
      r_type  <= XACT_WR;
      r_cs    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
    end else if (i_start) begin
      // Strobes are re-decoded on every start, even back-to-back.
      r_phase <= XS_DRIVE;
      r_cnt   <= '0;
      r_type  <= i_type;
      r_cs    <= 1'b1;
      r_rd    <= (i_type == XACT_RD);
      r_wr    <= (i_type == XACT_WR);
      r_addr  <= i_addr;
      if (i_type == XACT_WR) r_dout <= i_data;
    end else begin
      case (r_phase)
        XS_DRIVE: begin
          if (w_drv_end) begin
            r_cs    <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_phase <= HAS_GAP ? XS_GAP : XS_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        XS_GAP: begin
          if (w_gap_end) r_phase <= XS_IDLE;
          else           r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_movimiento_sequencer.sv
// control_movimiento_sequencer
// Bus master that programs the motion peripheral's nine registers from a
// host-loaded shadow bank: SS=0, RV1..PHI_A, SS=shadow, optionally a
// read-back verify pass, then a one-cycle done pulse. abort finishes the
// current transaction, writes SS=0 and ends with err set.
// Build option: define CONTROL_MOVIMIENTO_READBACK_EN to add the VERIFY pass.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   cfg_we/cfg_idx/cfg_data        shadow bank write (idle only)
//   go, abort                      start / safe-stop the sequence
//   busy, done, err                status (err sticky until next go)
//   p_cs/p_rd/p_wr/p_addr/p_dout   peripheral bus outputs
//   p_din                          peripheral read data
module control_movimiento_sequencer
  import control_movimiento_pkg::*;
#(
  parameter int unsigned WR_CYCLES  = 1,
  parameter int unsigned RD_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [15:0] cfg_data,
  input  logic        go,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        p_cs,
  output logic        p_rd,
  output logic        p_wr,
  output logic [3:0]  p_addr,
  output logic [15:0] p_dout,
  input  logic [15:0] p_din
);

  seq_state_t  r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        r_abort, r_busy, r_done, r_err;
  logic [15:0] r_shadow [NUM_REGS];

  logic        w_start;
  xact_t       w_type;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic        w_last, w_sample, w_rd;
  logic        w_in_seq, w_abort_req, w_enter_abort, w_mismatch;

`ifdef CONTROL_MOVIMIENTO_READBACK_EN
  assign w_in_seq   = r_state inside {ST_STOP, ST_LOAD, ST_START, ST_VERIFY};
  assign w_mismatch = (r_state == ST_VERIFY) && w_sample && (p_din != r_shadow[r_idx]);
  assign p_rd       = w_rd;
`else
  logic w_unused_ok;
  assign w_in_seq    = r_state inside {ST_STOP, ST_LOAD, ST_START};
  assign w_mismatch  = 1'b0;
  assign p_rd        = 1'b0;
  assign w_unused_ok = ^{p_din, w_sample, w_rd};
`endif

  // An abort seen earlier in the transaction is remembered until it ends.
  assign w_abort_req = r_abort | abort;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_start       = 1'b0;
    w_type        = XACT_WR;
    w_addr        = REG_SS;
    w_data        = '0;
    w_enter_abort = 1'b0;
    if (w_in_seq && w_last && w_abort_req) begin
      w_start       = 1'b1;
      w_enter_abort = 1'b1;
      w_state_nxt   = ST_ABORT_STOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            w_start     = 1'b1;
            w_state_nxt = ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_last) begin
            w_start     = 1'b1;
            w_idx_nxt   = REG_RV1;
            w_addr      = REG_RV1;
            w_data      = r_shadow[REG_RV1];
            w_state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_last) begin
            w_start = 1'b1;
            if (r_idx == REG_PHI_A) begin
              w_addr      = REG_SS;
              w_data      = r_shadow[REG_SS];
              w_state_nxt = ST_START;
            end else begin
              w_idx_nxt = idx_inc(r_idx);
              w_addr    = w_idx_nxt;
              w_data    = r_shadow[w_idx_nxt];
            end
          end
        end
        ST_START: begin
          if (w_last) begin
`ifdef CONTROL_MOVIMIENTO_READBACK_EN
            w_start     = 1'b1;
            w_type      = XACT_RD;
            w_idx_nxt   = REG_SS;
            w_addr      = REG_SS;
            w_state_nxt = ST_VERIFY;
`else
            w_state_nxt = ST_FIN;
`endif
          end
        end
`ifdef CONTROL_MOVIMIENTO_READBACK_EN
        ST_VERIFY: begin
          if (w_last) begin
            if (r_idx == REG_PHI_A) begin
              w_state_nxt = ST_FIN;
            end else begin
              w_start   = 1'b1;
              w_type    = XACT_RD;
              w_idx_nxt = idx_inc(r_idx);
              w_addr    = w_idx_nxt;
            end
          end
        end
`endif
        ST_ABORT_STOP: begin
          if (w_last) w_state_nxt = ST_FIN;
        end
        ST_FIN:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_abort <= w_in_seq && w_abort_req && !w_last;
      r_busy  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
      r_done  <= (w_state_nxt == ST_FIN);
      if (r_state == ST_IDLE && go)
        r_err <= 1'b0;
      else if ((cfg_we && r_busy) || w_enter_abort || w_mismatch)
        r_err <= 1'b1;
      if (cfg_we && !r_busy && cfg_idx <= REG_PHI_A)
        r_shadow[cfg_idx] <= cfg_data;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  cm_bus_xact #(
    .WR_CYCLES  (WR_CYCLES),
    .RD_CYCLES  (RD_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_xact (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_type   (w_type),
    .i_addr   (w_addr),
    .i_data   (w_data),
    .o_last   (w_last),
    .o_sample (w_sample),
    .o_cs     (p_cs),
    .o_rd     (w_rd),
    .o_wr     (p_wr),
    .o_addr   (p_addr),
    .o_dout   (p_dout)
  );

endmodule
